conv_encoder_axis: RTL and testbench

//  Parametrised rate-1/N feed-forward convolutional encoder, constraint length K.

---
 rtl/conv_encoder_axis_pkg.sv | 16 +
 rtl/conv_encoder_axis_prbs7.sv | 24 ++
 rtl/conv_encoder_axis.sv | 119 +++++++++++
 tb/tb_conv_encoder_axis.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_encoder_axis_pkg.sv
// Shared types and helpers for the convolutional encoder slice.
package conv_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    TAIL = 1'b1
  } state_t;

  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  // Even parity over a window of up to nine taps (K <= 9).
  function automatic logic parity(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/conv_encoder_axis_prbs7.sv
// PRBS-7 (x^7 + x^6 + 1) self-test bit source; advances only when en is high.
module prbs7_gen
  import conv_pkg::*;
(
  input  logic clk,
  input  logic srst,
  input  logic en,
  output logic bit_o
);

  logic [6:0] lfsr;

  // Fibonacci LFSR: feedback from stages 7 and 6, oldest bit presented on bit_o.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      lfsr <= PRBS7_SEED;
    end else if (en) begin
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
    end
  end

  assign bit_o = lfsr[6];

endmodule

// File: rtl/conv_encoder_axis.sv
// Rate-1/N feed-forward convolutional encoder with valid/ready streaming,
// optional per-frame zero-tail termination and an optional PRBS-7 data source.
module conv_encoder_axis
  import conv_pkg::*;
#(
  parameter int unsigned  K        = 3,
  parameter int unsigned  N        = 2,
  parameter logic [K-1:0] G [N]    = '{3'b111, 3'b101},
  parameter int unsigned  TERM     = 1,
  parameter int unsigned  USE_PRBS = 0
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         s_data,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [N-1:0] m_coded,
  output logic         m_last,
  output logic         busy
);

  if (K < 2 || K > 9) begin : g_bad_k
    $error("conv_encoder_axis: K=%0d outside 2..9", K);
  end
  if (N < 2 || N > 4) begin : g_bad_n
    $error("conv_encoder_axis: N=%0d outside 2..4", N);
  end

  localparam logic TERM_EN = (TERM != 0);

  state_t       state;
  logic [K-2:0] sr;
  logic [3:0]   tail_cnt;
  logic         u_in;
  logic         u;
  logic         load;
  logic         accept;
  logic         tail_step;
  logic [K-1:0] w;
  logic [N-1:0] coded;

  if (USE_PRBS != 0) begin : g_prbs
    logic prbs_bit;
    prbs7_gen u_prbs (
      .clk   (clk),
      .srst  (srst),
      .en    (accept),
      .bit_o (prbs_bit)
    );
    assign u_in = prbs_bit;
  end else begin : g_data
    assign u_in = s_data;
  end

  assign load      = !m_valid || m_ready;
  assign s_ready   = !srst && (state == RUN) && load;
  assign accept    = s_valid && s_ready;
  assign tail_step = (state == TAIL) && load;
  assign busy      = (state == TAIL) || m_valid;

  // Encoder window: current bit on top, tail steps feed zeros.
  always_comb begin
    u     = (state == TAIL) ? 1'b0 : u_in;
    w     = {u, sr};
    coded = '0;
    for (int unsigned n = 0; n < N; n++) begin
      coded[n] = parity(9'(w & G[n]));
    end
  end

  // FSM, shift register and single output register; w[K-1:1] is the shifted
  // register for every K, including K=2 where it collapses to the bit itself.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state    <= RUN;
      sr       <= '0;
      tail_cnt <= '0;
      m_valid  <= 1'b0;
      m_coded  <= '0;
      m_last   <= 1'b0;
    end else begin
      if (load) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      if (accept) begin
        m_valid <= 1'b1;
        m_coded <= coded;
        if (s_last && TERM_EN) begin
          sr       <= w[K-1:1];
          state    <= TAIL;
          tail_cnt <= 4'(K - 2);
          m_last   <= 1'b0;
        end else if (s_last) begin
          m_last <= 1'b1;
        end else begin
          sr     <= w[K-1:1];
          m_last <= 1'b0;
        end
      end else if (tail_step) begin
        m_valid <= 1'b1;
        m_coded <= coded;
        if (tail_cnt == '0) begin
          sr     <= '0;
          m_last <= 1'b1;
          state  <= RUN;
        end else begin
          sr       <= w[K-1:1];
          m_last   <= 1'b0;
          tail_cnt <= tail_cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_encoder_axis.sv
// Self-checking bench for conv_encoder_axis: directed vectors, randomized
// frames against a convolution reference model, TERM=0 and PRBS instances.
module tb_conv_encoder_axis;

  localparam int unsigned K = 3;
  localparam int unsigned N = 2;
  localparam logic [K-1:0] GB [N] = '{3'b111, 3'b101};
  localparam logic [N:0] EXP_DIR [6] = '{3'b011, 3'b001, 3'b000, 3'b010, 3'b010, 3'b111};

  logic clk = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic a_sv = 0, a_sd = 0, a_sl = 0, a_mr = 0, a_sr, a_mv, a_ml, a_busy;
  logic b_sv = 0, b_sd = 0, b_sl = 0, b_mr = 0, b_sr, b_mv, b_ml, b_busy;
  logic c_sv = 0, c_sd = 0, c_sl = 0, c_mr = 0, c_sr, c_mv, c_ml, c_busy;
  logic [N-1:0] a_mc, b_mc, c_mc;

  conv_encoder_axis #(.K(K), .N(N), .G(GB), .TERM(1), .USE_PRBS(0)) dut_a (
    .clk(clk), .srst(srst), .s_valid(a_sv), .s_ready(a_sr), .s_data(a_sd), .s_last(a_sl),
    .m_valid(a_mv), .m_ready(a_mr), .m_coded(a_mc), .m_last(a_ml), .busy(a_busy));
  conv_encoder_axis #(.K(K), .N(N), .G(GB), .TERM(0), .USE_PRBS(0)) dut_b (
    .clk(clk), .srst(srst), .s_valid(b_sv), .s_ready(b_sr), .s_data(b_sd), .s_last(b_sl),
    .m_valid(b_mv), .m_ready(b_mr), .m_coded(b_mc), .m_last(b_ml), .busy(b_busy));
  conv_encoder_axis #(.K(K), .N(N), .G(GB), .TERM(1), .USE_PRBS(1)) dut_c (
    .clk(clk), .srst(srst), .s_valid(c_sv), .s_ready(c_sr), .s_data(c_sd), .s_last(c_sl),
    .m_valid(c_mv), .m_ready(c_mr), .m_coded(c_mc), .m_last(c_ml), .busy(c_busy));

  // Collected output symbols {last, coded}, taken when a transfer will occur.
  logic [N:0] got_a[$], got_b[$], got_c[$];
  always @(negedge clk) begin
    if (!srst) begin
      if (a_mv && a_mr) got_a.push_back({a_ml, a_mc});
      if (b_mv && b_mr) got_b.push_back({b_ml, b_mc});
      if (c_mv && c_mr) got_c.push_back({c_ml, c_mc});
    end
  end

  // Reference model: c_n(t) = sum_j g_n[j] * u(t-j) mod 2, hist[0] = u(t-1).
  logic       hist[$];
  logic [N:0] exp_q[$];
  logic       sr_trace[$];

  function automatic void model_reset();
    hist.delete();
    for (int unsigned i = 0; i < K - 1; i++) hist.push_back(1'b0);
  endfunction

  function automatic logic [N-1:0] conv_out(input logic u);
    logic [N-1:0] c;
    logic b;
    c = '0;
    for (int unsigned n = 0; n < N; n++) begin
      for (int unsigned j = 0; j < K; j++) begin
        b = (j == 0) ? u : hist[j-1];
        c[n] = c[n] ^ (GB[n][K-1-j] & b);
      end
    end
    return c;
  endfunction

  function automatic void model_bit(input logic u, input logic last, input logic term);
    logic [N-1:0] c;
    c = conv_out(u);
    if (last && !term) begin
      exp_q.push_back({1'b1, c});
    end else begin
      hist.push_front(u);
      void'(hist.pop_back());
      exp_q.push_back({1'b0, c});
      if (last) begin
        for (int unsigned t = 0; t < K - 1; t++) begin
          c = conv_out(1'b0);
          hist.push_front(1'b0);
          void'(hist.pop_back());
          exp_q.push_back({(t == K - 2), c});
        end
      end
    end
  endfunction

  // Drives one stream into dut_a; rmode 0 = always ready, 2 = random ready.
  task automatic drive_a(input logic bits[$], input logic lasts[$],
                         input int unsigned pv, input int unsigned rmode);
    int unsigned idx = 0;
    int unsigned cyc = 0;
    logic done = 1'b0;
    sr_trace.delete();
    while (!done) begin
      if (idx < bits.size()) begin
        a_sv = ($urandom_range(99) < pv);
        a_sd = bits[idx];
        a_sl = lasts[idx];
      end else begin
        a_sv = 1'b0; a_sd = 1'b0; a_sl = 1'b0;
      end
      a_mr = (rmode == 0) ? 1'b1 : ($urandom_range(99) < 70);
      @(negedge clk);
      sr_trace.push_back(a_sr);
      if (a_sv && a_sr) idx++;
      else if (idx >= bits.size() && !a_busy) done = 1'b1;
      cyc++;
      if (!done && cyc > 3000) begin
        checks++; errors++;
        $display("FAIL drive_a_timeout accepted=%0d required=%0d", idx, bits.size());
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    a_sv = 1'b0; a_sl = 1'b0; a_mr = 1'b0;
  endtask

  task automatic test_reset();
    a_sv = 1'b1; b_sv = 1'b1; c_sv = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (a_mv !== 1'b0) begin errors++; $display("FAIL rst_m_valid got=%b exp=0", a_mv); end
    checks++; if (a_mc !== '0) begin errors++; $display("FAIL rst_m_coded got=%b exp=00", a_mc); end
    checks++; if (a_ml !== 1'b0) begin errors++; $display("FAIL rst_m_last got=%b exp=0", a_ml); end
    checks++; if (a_sr !== 1'b0) begin errors++; $display("FAIL rst_s_ready got=%b exp=0", a_sr); end
    checks++; if (c_sr !== 1'b0) begin errors++; $display("FAIL rst_prbs_s_ready got=%b exp=0", c_sr); end
    a_sv = 1'b0; b_sv = 1'b0; c_sv = 1'b0;
    srst = 1'b0;
    @(negedge clk);
    checks++; if (a_sr !== 1'b1) begin errors++; $display("FAIL post_rst_s_ready got=%b exp=1", a_sr); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got=%b exp=0", a_busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic bits[$] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic lasts[$] = '{1'b0, 1'b0, 1'b0, 1'b1};
    got_a.delete();
    drive_a(bits, lasts, 100, 0);
    checks++;
    if (got_a.size() !== 6) begin errors++; $display("FAIL dir_count got=%0d exp=6", got_a.size()); end
    for (int unsigned i = 0; i < 6 && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== EXP_DIR[i]) begin
        errors++; $display("FAIL dir_sym[%0d] got=%b exp=%b", i, got_a[i], EXP_DIR[i]);
      end
    end
  endtask

  task automatic test_ready_toggle();
    logic bits[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    int unsigned idx = 0;
    int unsigned cyc = 0;
    logic done = 1'b0;
    logic hold_pend = 1'b0;
    logic [N:0] hold_val = '0;
    got_a.delete();
    while (!done) begin
      a_sv = (idx < 4);
      a_sd = (idx < 4) ? bits[idx] : 1'b0;
      a_sl = (idx == 3);
      a_mr = (cyc % 2 == 0);
      @(negedge clk);
      if (hold_pend) begin
        checks++;
        if (a_mv !== 1'b1 || {a_ml, a_mc} !== hold_val) begin
          errors++; $display("FAIL hold got=%b%b exp=1%b", a_mv, {a_ml, a_mc}, hold_val);
        end
      end
      if (a_mv && !a_mr) begin
        checks++;
        if (a_sr !== 1'b0) begin errors++; $display("FAIL stall_s_ready got=%b exp=0", a_sr); end
        hold_pend = 1'b1;
        hold_val  = {a_ml, a_mc};
      end else begin
        hold_pend = 1'b0;
      end
      if (a_sv && a_sr) idx++;
      else if (idx >= 4 && !a_busy) done = 1'b1;
      cyc++;
      if (!done && cyc > 200) begin
        checks++; errors++; $display("FAIL toggle_timeout accepted=%0d required=4", idx);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    a_sv = 1'b0; a_sl = 1'b0; a_mr = 1'b0;
    checks++;
    if (got_a.size() !== 6) begin errors++; $display("FAIL toggle_count got=%0d exp=6", got_a.size()); end
    for (int unsigned i = 0; i < 6 && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== EXP_DIR[i]) begin
        errors++; $display("FAIL toggle_sym[%0d] got=%b exp=%b", i, got_a[i], EXP_DIR[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic bits[$];
    logic lasts[$];
    int unsigned l1 = $urandom_range(2, 6);
    int unsigned l2 = $urandom_range(2, 6);
    int unsigned zeros = 0;
    exp_q.delete();
    model_reset();
    for (int unsigned i = 0; i < l1; i++) begin
      bits.push_back(1'($urandom)); lasts.push_back(i == l1 - 1);
      model_bit(bits[i], lasts[i], 1'b1);
    end
    model_reset();
    for (int unsigned i = 0; i < l2; i++) begin
      bits.push_back(1'($urandom)); lasts.push_back(i == l2 - 1);
      model_bit(bits[l1+i], lasts[l1+i], 1'b1);
    end
    got_a.delete();
    drive_a(bits, lasts, 100, 0);
    checks++;
    if (got_a.size() !== exp_q.size()) begin
      errors++; $display("FAIL b2b_count got=%0d exp=%0d", got_a.size(), exp_q.size());
    end
    for (int unsigned i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_sym[%0d] got=%b exp=%b", i, got_a[i], exp_q[i]);
      end
    end
    for (int unsigned i = 0; i < l1 + K - 1 + l2 && i < sr_trace.size(); i++)
      if (sr_trace[i] == 1'b0) zeros++;
    checks++;
    if (zeros !== K - 1) begin errors++; $display("FAIL b2b_tail_cycles got=%0d exp=%0d", zeros, K - 1); end
    checks++;
    if (sr_trace.size() <= l1 + K - 1 || sr_trace[l1+K-1] !== 1'b1) begin
      errors++; $display("FAIL b2b_restart s_ready not high on cycle %0d after tail", l1 + K - 1);
    end
  endtask

  task automatic test_random();
    logic bits[$];
    logic lasts[$];
    int unsigned len;
    exp_q.delete();
    model_reset();
    for (int unsigned f = 0; f < 6; f++) begin
      len = (f == 0) ? 1 : $urandom_range(1, 10);
      for (int unsigned i = 0; i < len; i++) begin
        bits.push_back(1'($urandom));
        lasts.push_back(i == len - 1);
        model_bit(bits[bits.size()-1], lasts[lasts.size()-1], 1'b1);
      end
    end
    got_a.delete();
    drive_a(bits, lasts, 70, 2);
    checks++;
    if (got_a.size() !== exp_q.size()) begin
      errors++; $display("FAIL rand_count got=%0d exp=%0d", got_a.size(), exp_q.size());
    end
    for (int unsigned i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand_sym[%0d] got=%b exp=%b", i, got_a[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_term0();
    logic bits[$] = '{1'b1, 1'b1, 1'b0};
    logic lasts[$] = '{1'b0, 1'b1, 1'b1};
    logic [N:0] dir3 [3] = '{3'b011, 3'b110, 3'b101};
    int unsigned cyc = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      bits.push_back(1'($urandom)); lasts.push_back($urandom_range(3) == 0);
    end
    exp_q.delete();
    model_reset();
    for (int unsigned i = 0; i < bits.size(); i++) model_bit(bits[i], lasts[i], 1'b0);
    got_b.delete();
    b_mr = 1'b1;
    for (int unsigned i = 0; i < bits.size(); i++) begin
      b_sv = 1'b1; b_sd = bits[i]; b_sl = lasts[i];
      @(negedge clk);
      checks++;
      if (b_sr !== 1'b1) begin errors++; $display("FAIL t0_s_ready[%0d] got=%b exp=1", i, b_sr); end
      @(posedge clk); #1;
    end
    b_sv = 1'b0; b_sl = 1'b0;
    while (b_busy && cyc < 20) begin @(posedge clk); #1; cyc++; end
    b_mr = 1'b0;
    checks++;
    if (got_b.size() !== exp_q.size()) begin
      errors++; $display("FAIL t0_count got=%0d exp=%0d", got_b.size(), exp_q.size());
    end
    for (int unsigned i = 0; i < 3 && i < got_b.size(); i++) begin
      checks++;
      if (got_b[i] !== dir3[i]) begin errors++; $display("FAIL t0_dir[%0d] got=%b exp=%b", i, got_b[i], dir3[i]); end
    end
    for (int unsigned i = 3; i < exp_q.size() && i < got_b.size(); i++) begin
      checks++;
      if (got_b[i] !== exp_q[i]) begin errors++; $display("FAIL t0_sym[%0d] got=%b exp=%b", i, got_b[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_tail();
    logic bits1[$] = '{1'b1};
    logic lasts1[$] = '{1'b1};
    logic fbits[3] = '{1'b1, 1'b0, 1'b1};
    int unsigned lasts_seen = 0;
    got_a.delete();
    a_mr = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      a_sv = 1'b1; a_sd = fbits[i]; a_sl = (i == 2);
      @(posedge clk); #1;
    end
    a_sv = 1'b0; a_sl = 1'b0;
    #1 srst = 1'b1;
    #1;
    checks++; if (a_mv !== 1'b0) begin errors++; $display("FAIL midtail_m_valid got=%b exp=0", a_mv); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL midtail_busy got=%b exp=0", a_busy); end
    #3 srst = 1'b0;
    @(posedge clk); #1;
    a_mr = 1'b0;
    foreach (got_a[i]) if (got_a[i][N]) lasts_seen++;
    checks++;
    if (got_a.size() !== 2 || lasts_seen !== 0) begin
      errors++; $display("FAIL midtail_aborted got=%0d syms/%0d last exp=2 syms/0 last", got_a.size(), lasts_seen);
    end
    exp_q.delete();
    model_reset();
    model_bit(1'b1, 1'b1, 1'b1);
    got_a.delete();
    drive_a(bits1, lasts1, 100, 0);
    checks++;
    if (got_a.size() !== exp_q.size()) begin
      errors++; $display("FAIL after_rst_count got=%0d exp=%0d", got_a.size(), exp_q.size());
    end
    for (int unsigned i = 0; i < exp_q.size() && i < got_a.size(); i++) begin
      checks++;
      if (got_a[i] !== exp_q[i]) begin errors++; $display("FAIL after_rst_sym[%0d] got=%b exp=%b", i, got_a[i], exp_q[i]); end
    end
  endtask

  task automatic test_prbs();
    localparam int unsigned NS = 134;
    logic s[NS];
    int unsigned bad_ready = 0;
    for (int unsigned n = 0; n < NS; n++) s[n] = (n < 7) ? 1'b1 : (s[n-7] ^ s[n-6]);
    exp_q.delete();
    model_reset();
    for (int unsigned n = 0; n < NS; n++) model_bit(s[n], 1'b0, 1'b1);
    got_c.delete();
    c_mr = 1'b1;
    for (int unsigned n = 0; n < NS; n++) begin
      c_sv = 1'b1; c_sd = 1'($urandom); c_sl = 1'b0;
      @(negedge clk);
      if (c_sr !== 1'b1) bad_ready++;
      @(posedge clk); #1;
    end
    c_sv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    c_mr = 1'b0;
    checks++;
    if (bad_ready !== 0) begin errors++; $display("FAIL prbs_s_ready low_cycles=%0d exp=0", bad_ready); end
    checks++;
    if (got_c.size() !== NS) begin errors++; $display("FAIL prbs_count got=%0d exp=%0d", got_c.size(), NS); end
    for (int unsigned i = 0; i < NS && i < got_c.size(); i++) begin
      checks++;
      if (got_c[i] !== exp_q[i]) begin errors++; $display("FAIL prbs_sym[%0d] got=%b exp=%b", i, got_c[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ready_toggle();
    test_back_to_back();
    test_random();
    test_term0();
    test_reset_mid_tail();
    test_prbs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
